// File: rtl/fp_addsub_result_collector.sv
// Result collector at the tail of the three-stage FP add/sub datapath.
// Issue throttling, stage-3 capture and a FWFT result/flag FIFO with a valid/ready output.
module fp_addsub_result_collector #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              issue_req,
  output logic              pipe_enable,
  input  logic              enable_stage1,
  input  logic              enable_stage3,
  input  logic [DATA_W-1:0] result_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [DATA_W-1:0] res_data,
  output logic [FLAG_W-1:0] res_flags,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy,
  output logic              err_overflow,
  input  logic              err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [FLAG_W-1:0] flag_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;
  logic             overflow_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pop          = 1'b0;
    push         = 1'b0;
    overflow_hit = 1'b0;
    count_next   = count;
    pop          = res_valid && res_ready;
    push         = enable_stage3 && ((count < FULL_CNT) || pop);
    overflow_hit = enable_stage3 && (count == FULL_CNT) && !pop;
    count_next   = count + CNT_W'(push) - CNT_W'(pop);
  end

  assign res_valid = (count != '0);
  assign res_count = count;
  assign res_data  = data_mem[rd_ptr];
  assign res_flags = flag_mem[rd_ptr];

  // NOTE: control state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      busy         <= 1'b0;
      pipe_enable  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (enable_stage1)      busy <= 1'b1;
      else if (enable_stage3) busy <= 1'b0;

      // The sequencer aborts if fsm_enable drops, so only move it between operations.
      if (!busy || enable_stage3)
        pipe_enable <= issue_req && (count_next < FULL_CNT);

      if (overflow_hit) err_overflow <= 1'b1;
      else if (err_clr) err_overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; an entry is only ever read after it has been written.
  always_ff @(posedge clk_in) begin
    if (push) begin
      data_mem[wr_ptr] <= result_in;
      flag_mem[wr_ptr] <= flags_in;
    end
  end

endmodule

// File: tb/tb_fp_addsub_result_collector.sv
// Bench for fp_addsub_result_collector: sequencer model drives the strobes, a queue model
// predicts every output each cycle, and directed steps pin literal values.
module tb_fp_addsub_result_collector;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  localparam logic [1:0] SQ_IDLE = 2'd0;
  localparam logic [1:0] SQ_S2   = 2'd1;
  localparam logic [1:0] SQ_S3   = 2'd2;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              issue_req;
  logic              pipe_enable;
  logic              enable_stage1;
  logic              enable_stage3;
  logic [DATA_W-1:0] result_in;
  logic [FLAG_W-1:0] flags_in;
  logic [DATA_W-1:0] res_data;
  logic [FLAG_W-1:0] res_flags;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  logic              busy;
  logic              err_overflow;
  logic              err_clr;

  always #5 clk_in = ~clk_in;

  fp_addsub_result_collector #(
    .DATA_W(DATA_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .reset(reset), .issue_req(issue_req), .pipe_enable(pipe_enable),
    .enable_stage1(enable_stage1), .enable_stage3(enable_stage3),
    .result_in(result_in), .flags_in(flags_in),
    .res_data(res_data), .res_flags(res_flags), .res_valid(res_valid),
    .res_ready(res_ready), .res_count(res_count), .busy(busy),
    .err_overflow(err_overflow), .err_clr(err_clr)
  );

  // Operation n produces a recognisable result; op 0 is pi in single precision.
  function automatic logic [31:0] val_of(input logic [7:0] n);
    return (n == 8'd0) ? 32'h40490FDB : 32'h3F800000 + {24'd0, n};
  endfunction
  function automatic logic [3:0] flg_of(input logic [7:0] n);
    return (n == 8'd0) ? 4'b0001 : n[3:0];
  endfunction

  // Stage sequencer model: stage1 in the cycle fsm_enable is seen while idle, then stage2, stage3.
  logic [1:0]  sq;
  logic [7:0]  op_num;
  logic [31:0] op_data;
  logic [3:0]  op_flags;
  logic        force_s3;
  logic [31:0] frc_data;
  logic [3:0]  frc_flags;

  assign enable_stage1 = (sq == SQ_IDLE) && pipe_enable;
  assign enable_stage3 = (sq == SQ_S3) || force_s3;
  assign result_in     = force_s3 ? frc_data  : op_data;
  assign flags_in      = force_s3 ? frc_flags : op_flags;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sq       <= SQ_IDLE;
      op_num   <= 8'd0;
      op_data  <= 32'd0;
      op_flags <= 4'd0;
    end else if (!pipe_enable) begin
      sq <= SQ_IDLE;
    end else begin
      case (sq)
        SQ_IDLE: begin
          sq       <= SQ_S2;
          op_data  <= val_of(op_num);
          op_flags <= flg_of(op_num);
          op_num   <= op_num + 8'd1;
        end
        SQ_S2:   sq <= SQ_S3;
        default: sq <= SQ_IDLE;
      endcase
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: a queue of results plus the flags that describe the issue throttle.
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  f;
  } entry_t;

  entry_t m_q[$];
  logic   m_pe   = 1'b0;
  logic   m_busy = 1'b0;
  logic   m_err  = 1'b0;

  initial begin
    forever begin
      @(posedge clk_in or posedge reset);
      if (reset) begin
        m_q.delete();
        m_pe   = 1'b0;
        m_busy = 1'b0;
        m_err  = 1'b0;
      end else begin
        automatic logic was_busy = m_busy;
        automatic logic dropped  = 1'b0;
        if (m_q.size() != 0 && res_ready) void'(m_q.pop_front());
        if (enable_stage3) begin
          if (m_q.size() < DEPTH) m_q.push_back('{d: result_in, f: flags_in});
          else dropped = 1'b1;
        end
        if (dropped)      m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (enable_stage1)      m_busy = 1'b1;
        else if (enable_stage3) m_busy = 1'b0;
        if (!was_busy || enable_stage3) m_pe = issue_req && (m_q.size() < DEPTH);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk_in);
      if (!reset) begin
        check("m_pipe_enable", {63'd0, pipe_enable}, {63'd0, m_pe});
        check("m_busy", {63'd0, busy}, {63'd0, m_busy});
        check("m_err_overflow", {63'd0, err_overflow}, {63'd0, m_err});
        check("m_res_count", {61'd0, res_count}, 64'(m_q.size()));
        check("m_res_valid", {63'd0, res_valid}, {63'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
          check("m_res_data", {32'd0, res_data}, {32'd0, m_q[0].d});
          check("m_res_flags", {60'd0, res_flags}, {60'd0, m_q[0].f});
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    logic prev_pe;
    logic filled;
    reset     = 1'b1;
    issue_req = 1'b0;
    res_ready = 1'b0;
    err_clr   = 1'b0;
    force_s3  = 1'b0;
    frc_data  = 32'd0;
    frc_flags = 4'd0;
    step(3);
    reset     = 1'b0;

    // Test 1: first-result latency, then asynchronous reset mid-operation.
    issue_req = 1'b1;
    step();
    check("t1_pe_rise", {63'd0, pipe_enable}, 64'd1);
    step(2);
    check("t1_not_yet_valid", {63'd0, res_valid}, 64'd0);
    issue_req = 1'b0;
    step();
    check("t1_valid", {63'd0, res_valid}, 64'd1);
    check("t1_data", {32'd0, res_data}, 64'h40490FDB);
    check("t1_flags", {60'd0, res_flags}, 64'h1);
    issue_req = 1'b1;
    step();
    @(posedge clk_in);
    #2 reset = 1'b1;
    #1;
    check("t1_rst_pe", {63'd0, pipe_enable}, 64'd0);
    check("t1_rst_valid", {63'd0, res_valid}, 64'd0);
    check("t1_rst_count", {61'd0, res_count}, 64'd0);
    check("t1_rst_busy", {63'd0, busy}, 64'd0);
    check("t1_rst_err", {63'd0, err_overflow}, 64'd0);
    step(2);
    reset = 1'b0;

    // Test 2: consumer stalled, fill to DEPTH.
    prev_pe = 1'b0;
    filled  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (res_count == 3'd4) begin
        filled = 1'b1;
        break;
      end
      prev_pe = pipe_enable;
    end
    check("t2_filled", {63'd0, filled}, 64'd1);
    check("t2_pe_before_last", {63'd0, prev_pe}, 64'd1);
    check("t2_pe_fall", {63'd0, pipe_enable}, 64'd0);
    step(6);
    check("t2_count", {61'd0, res_count}, 64'd4);
    check("t2_err", {63'd0, err_overflow}, 64'd0);
    check("t2_head", {32'd0, res_data}, 64'h40490FDB);

    // Test 3: single pops re-open issue; pushes wrap the pointers.
    for (int k = 1; k <= 2; k++) begin
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("t3_count_dec", {61'd0, res_count}, 64'd3);
      check("t3_pe_rerise", {63'd0, pipe_enable}, 64'd1);
      check("t3_head", {32'd0, res_data}, 64'(32'h3F800000 + k));
      step(2);
      check("t3_not_yet", {61'd0, res_count}, 64'd3);
      step();
      check("t3_count_full", {61'd0, res_count}, 64'd4);
    end

    // Test 4: push and pop together while full.
    force_s3  = 1'b1;
    frc_data  = 32'hC0000000;
    frc_flags = 4'b1000;
    res_ready = 1'b1;
    step();
    force_s3  = 1'b0;
    res_ready = 1'b0;
    check("t4_count", {61'd0, res_count}, 64'd4);
    check("t4_head", {32'd0, res_data}, 64'h3F800003);
    check("t4_err", {63'd0, err_overflow}, 64'd0);

    // Test 5: overflow violation, sticky flag, set beats clear.
    force_s3 = 1'b1;
    frc_data = 32'hDEADBEEF;
    step();
    force_s3 = 1'b0;
    check("t5_err_set", {63'd0, err_overflow}, 64'd1);
    check("t5_count", {61'd0, res_count}, 64'd4);
    check("t5_head", {32'd0, res_data}, 64'h3F800003);
    step(2);
    check("t5_sticky", {63'd0, err_overflow}, 64'd1);
    force_s3 = 1'b1;
    err_clr  = 1'b1;
    step();
    force_s3 = 1'b0;
    err_clr  = 1'b0;
    check("t5_set_wins", {63'd0, err_overflow}, 64'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_cleared", {63'd0, err_overflow}, 64'd0);

    // Test 6: drain, then drop issue_req during stage 2.
    issue_req = 1'b0;
    res_ready = 1'b1;
    step(5);
    check("t6_drained", {61'd0, res_count}, 64'd0);
    issue_req = 1'b1;
    step(2);
    check("t6_busy", {63'd0, busy}, 64'd1);
    issue_req = 1'b0;
    step();
    check("t6_pe_hold", {63'd0, pipe_enable}, 64'd1);
    step();
    check("t6_pe_fall", {63'd0, pipe_enable}, 64'd0);
    check("t6_idle", {63'd0, busy}, 64'd0);
    check("t6_valid", {63'd0, res_valid}, 64'd1);
    check("t6_data", {32'd0, res_data}, 64'h3F800006);
    check("t6_flags", {60'd0, res_flags}, 64'h6);
    step(3);
    check("t6_empty", {61'd0, res_count}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
